// File: rtl/iq_sample_buffer.sv
// iq_sample_buffer: captures a burst of {I,Q} samples from AXI-Stream into block RAM
// and replays it single-shot or looped through a two-entry output skid.
module iq_sample_buffer #(
    parameter int SAMPLE_W = 16,
    parameter int DEPTH    = 1024,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_W:0]       cmd_len,
    input  logic                  cmd_loop,
    input  logic                  cmd_start,
    input  logic                  cmd_stop,
    input  logic [2*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [2*SAMPLE_W-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W:0]       stored_len
);

    localparam int                DW      = 2*SAMPLE_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_PLAY, S_STOP} state_t;
    state_t state, state_next;

    logic [DW-1:0]     mem [DEPTH];
    logic [DW-1:0]     ram_q;
    logic [ADDR_W:0]   wr_cnt, wr_cnt_inc, target, len_clamped;
    logic [ADDR_W-1:0] rd_addr, rd_addr_sel;
    logic              rd_active, rd_valid, rd_last, rd_is_last, rd_issue;
    logic              loop_q, loop_sel;
    logic [DW-1:0]     q_data0, q_data1;
    logic              q_last0, q_last1;
    logic [1:0]        q_cnt;
    logic [2:0]        occ;
    logic              s_hs, pop, push;
    logic              cap_go, play_go, cap_end, stop_keep, stop_flush, done_set, err_set;

    always_comb begin
        s_axis_tready = (state == S_CAPTURE);
        busy          = (state != S_IDLE);
        m_axis_tvalid = (q_cnt != 2'd0);
        m_axis_tdata  = q_data0;
        // A stop forces tlast on whatever beat is presented in the same cycle.
        m_axis_tlast  = m_axis_tvalid &&
                        (q_last0 || state == S_STOP || (state == S_PLAY && cmd_stop));
        s_hs          = s_axis_tvalid && s_axis_tready;
        pop           = m_axis_tvalid && m_axis_tready;
        push          = rd_valid && state == S_PLAY && !cmd_stop;
        wr_cnt_inc    = wr_cnt + ONE_L;
        len_clamped   = (cmd_len == '0 || cmd_len > DEPTH_L) ? DEPTH_L : cmd_len;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        cap_go     = 1'b0;
        play_go    = 1'b0;
        cap_end    = 1'b0;
        stop_keep  = 1'b0;
        stop_flush = 1'b0;
        done_set   = 1'b0;
        err_set    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_start && !cmd_stop) begin
                    case (cmd_mode)
                        2'd1: begin
                            cap_go     = 1'b1;
                            state_next = S_CAPTURE;
                        end
                        2'd2: begin
                            if (stored_len != '0) begin
                                play_go    = 1'b1;
                                state_next = S_PLAY;
                            end else begin
                                err_set = 1'b1;
                            end
                        end
                        2'd3:    err_set = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_CAPTURE: begin
                if (cmd_stop || (s_hs && (s_axis_tlast || wr_cnt_inc == target))) begin
                    cap_end    = 1'b1;
                    done_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_PLAY: begin
                if (cmd_stop) begin
                    if (pop || q_cnt == 2'd0) begin
                        stop_flush = 1'b1;
                        done_set   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        stop_keep  = 1'b1;
                        state_next = S_STOP;
                    end
                end else if (pop && q_last0 && !loop_q) begin
                    done_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_STOP: begin
                if (pop) begin
                    done_set   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Reads are issued only while the skid plus the in-flight RAM read leave room.
    always_comb begin
        occ         = {1'b0, q_cnt} + {2'b00, rd_valid} - {2'b00, pop};
        rd_issue    = play_go || (state == S_PLAY && rd_active && !cmd_stop && occ <= 3'd1);
        rd_addr_sel = play_go ? '0 : rd_addr;
        rd_is_last  = ({1'b0, rd_addr_sel} == stored_len - ONE_L);
        loop_sel    = play_go ? cmd_loop : loop_q;
    end

    always_ff @(posedge clk) begin
        if (s_hs) mem[wr_cnt[ADDR_W-1:0]] <= s_axis_tdata;
        if (rd_issue) ram_q <= mem[rd_addr_sel];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt     <= '0;
            target     <= '0;
            stored_len <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            loop_q     <= 1'b0;
            rd_addr    <= '0;
            rd_active  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
        end else begin
            done     <= done_set;
            err      <= err_set;
            rd_valid <= rd_issue;
            rd_last  <= rd_is_last;
            if (cap_go) begin
                wr_cnt <= '0;
                target <= len_clamped;
            end else if (s_hs) begin
                wr_cnt <= wr_cnt_inc;
            end
            if (cap_end) stored_len <= s_hs ? wr_cnt_inc : wr_cnt;
            if (play_go) loop_q <= cmd_loop;
            if (stop_keep || stop_flush) begin
                rd_active <= 1'b0;
            end else if (rd_issue) begin
                if (rd_is_last) begin
                    rd_addr   <= '0;
                    rd_active <= loop_sel;
                end else begin
                    rd_addr   <= rd_addr_sel + ONE_A;
                    rd_active <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_cnt   <= 2'd0;
            q_data0 <= '0;
            q_data1 <= '0;
            q_last0 <= 1'b0;
            q_last1 <= 1'b0;
        end else if (stop_flush) begin
            q_cnt <= 2'd0;
        end else if (stop_keep) begin
            q_cnt <= 2'd1;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (q_cnt == 2'd0) begin
                        q_data0 <= ram_q;
                        q_last0 <= rd_last;
                    end else begin
                        q_data1 <= ram_q;
                        q_last1 <= rd_last;
                    end
                    q_cnt <= q_cnt + 2'd1;
                end
                2'b01: begin
                    q_data0 <= q_data1;
                    q_last0 <= q_last1;
                    q_cnt   <= q_cnt - 2'd1;
                end
                2'b11: begin
                    if (q_cnt == 2'd1) begin
                        q_data0 <= ram_q;
                        q_last0 <= rd_last;
                    end else begin
                        q_data0 <= q_data1;
                        q_last0 <= q_last1;
                        q_data1 <= ram_q;
                        q_last1 <= rd_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_sample_buffer.sv
// Directed record/replay sequence for iq_sample_buffer checked against an array model
// of stored samples and the expected beat stream derived from it.
module tb_iq_sample_buffer;

    localparam int SW = 16;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      cmd_mode;
    logic [AW:0]     cmd_len;
    logic            cmd_loop, cmd_start, cmd_stop;
    logic [2*SW-1:0] s_axis_tdata;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [2*SW-1:0] m_axis_tdata;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic            busy, done, err;
    logic [AW:0]     stored_len;

    iq_sample_buffer #(.SAMPLE_W(SW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .cmd_mode(cmd_mode), .cmd_len(cmd_len), .cmd_loop(cmd_loop),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .busy(busy), .done(done), .err(err), .stored_len(stored_len)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          s_acc = 0;
    bit          s_hs_seen;
    bit          stall_pending = 1'b0;
    logic [31:0] held_data;
    logic [32:0] got_q [$];
    logic [31:0] model_mem [0:D-1];
    int          model_len = 0;
    logic [31:0] offer [0:1099];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Samples what the DUT sees at the coming edge, then advances to 1ns after it.
    task automatic cycle();
        @(negedge clk);
        if (stall_pending) begin
            check("hold_valid", 64'(m_axis_tvalid), 64'd1);
            check("hold_data", 64'(m_axis_tdata), 64'(held_data));
        end
        if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
        stall_pending = m_axis_tvalid && !m_axis_tready && !reset;
        held_data     = m_axis_tdata;
        if (done) done_cnt++;
        if (err) err_cnt++;
        s_hs_seen = s_axis_tvalid && s_axis_tready;
        if (s_hs_seen) s_acc++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [1:0] mode, input int len, input bit loop);
        cmd_mode  = mode;
        cmd_len   = (AW+1)'(len);
        cmd_loop  = loop;
        cmd_start = 1'b1;
        cycle();
        cmd_start = 1'b0;
    endtask

    task automatic capture_run(input int len_cmd, input int n_offer, input int tlast_at);
        int target, exp_len, idx, n, d0, a0;
        target  = (len_cmd == 0 || len_cmd > D) ? D : len_cmd;
        exp_len = (tlast_at > 0 && tlast_at < target) ? tlast_at : target;
        d0 = done_cnt; a0 = s_acc; idx = 0; n = 0;
        start_cmd(2'd1, len_cmd, 1'b0);
        while (done_cnt == d0 && n < 6000) begin
            s_axis_tvalid = (idx < n_offer) && ($urandom_range(0, 3) != 0);
            s_axis_tdata  = offer[(idx < n_offer) ? idx : 0];
            s_axis_tlast  = (idx + 1 == tlast_at);
            cycle();
            if (s_hs_seen) idx++;
            n++;
        end
        check("cap_timeout", 64'(done_cnt != d0), 64'd1);
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        repeat (3) begin
            check("cap_tready_low", 64'(s_axis_tready), 64'd0);
            cycle();
        end
        s_axis_tvalid = 1'b0;
        check("cap_accepted", 64'(s_acc - a0), 64'(exp_len));
        check("cap_stored_len", 64'(stored_len), 64'(exp_len));
        check("cap_done_count", 64'(done_cnt - d0), 64'd1);
        check("cap_busy", 64'(busy), 64'd0);
        for (int i = 0; i < exp_len; i++) model_mem[i] = offer[i];
        model_len = exp_len;
    endtask

    task automatic play_run(input bit loop, input bit rand_ready, input int stop_after, input bit chk_lat);
        int d0, n, total;
        bit last_exp;
        got_q.delete();
        d0 = done_cnt;
        m_axis_tready = chk_lat ? 1'b0 : 1'b1;
        start_cmd(2'd2, 0, loop);
        if (chk_lat) begin
            check("lat_cycle1_valid", 64'(m_axis_tvalid), 64'd0);
            cycle();
            check("lat_cycle2_valid", 64'(m_axis_tvalid), 64'd1);
            check("lat_cycle2_data", 64'(m_axis_tdata), 64'(model_mem[0]));
        end
        n = 0;
        while (done_cnt == d0 && n < 8000) begin
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cmd_stop = (stop_after != 0 && got_q.size() == stop_after - 1 && m_axis_tvalid);
            cycle();
            cmd_stop = 1'b0;
            n++;
        end
        check("play_timeout", 64'(done_cnt != d0), 64'd1);
        m_axis_tready = 1'b1;
        repeat (3) cycle();
        m_axis_tready = 1'b0;
        total = (stop_after != 0) ? stop_after : model_len;
        check("play_beats", 64'(got_q.size()), 64'(total));
        for (int i = 0; i < total && i < got_q.size(); i++) begin
            last_exp = ((i + 1) % model_len == 0) || (i + 1 == total);
            check("play_data", 64'(got_q[i][31:0]), 64'(model_mem[i % model_len]));
            check("play_last", 64'(got_q[i][32]), 64'(last_exp));
        end
        check("play_done_count", 64'(done_cnt - d0), 64'd1);
        check("play_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int d;
        logic [15:0] iv, qv;
        reset = 1'b1;
        cmd_mode = 2'd0; cmd_len = '0; cmd_loop = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
        repeat (3) cycle();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_stored_len", 64'(stored_len), 64'd0);
        reset = 1'b0;
        cycle();

        // rejected and ignored commands
        d = err_cnt;
        start_cmd(2'd2, 0, 1'b0);
        cycle();
        check("err_play_empty", 64'(err_cnt - d), 64'd1);
        check("err_play_busy", 64'(busy), 64'd0);
        start_cmd(2'd3, 0, 1'b0);
        cycle();
        check("err_mode3", 64'(err_cnt - d), 64'd2);
        cmd_stop = 1'b1;
        start_cmd(2'd1, 8, 1'b0);
        cmd_stop = 1'b0;
        check("start_stop_busy", 64'(busy), 64'd0);
        check("start_stop_err", 64'(err_cnt - d), 64'd2);

        // I=k, Q=-k burst of 8
        for (int k = 1; k <= 8; k++) begin
            iv = 16'(k);
            qv = 16'(-k);
            offer[k-1] = {iv, qv};
        end
        capture_run(8, 8, 0);
        play_run(1'b0, 1'b0, 0, 1'b1);
        play_run(1'b0, 1'b1, 0, 1'b0);

        // early end on tlast
        for (int i = 0; i < 16; i++) offer[i] = $urandom;
        capture_run(16, 16, 5);
        play_run(1'b0, 1'b1, 0, 1'b0);

        // looped playback stopped on beat 10
        for (int k = 1; k <= 4; k++) begin
            iv = 16'(k);
            qv = 16'(-k);
            offer[k-1] = {iv, qv};
        end
        capture_run(4, 4, 0);
        play_run(1'b1, 1'b0, 10, 1'b0);

        // zero length means full depth
        for (int i = 0; i < 1100; i++) offer[i] = $urandom;
        capture_run(0, 1100, 0);
        play_run(1'b0, 1'b1, 0, 1'b0);

        // reset in the middle of playback
        m_axis_tready = 1'b0;
        start_cmd(2'd2, 0, 1'b0);
        repeat (3) cycle();
        check("mid_play_valid", 64'(m_axis_tvalid), 64'd1);
        d = done_cnt;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rst_play_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_play_stored_len", 64'(stored_len), 64'd0);
        check("rst_play_busy", 64'(busy), 64'd0);
        repeat (3) cycle();
        check("rst_play_no_done", 64'(done_cnt - d), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
